// File: rtl/scr1_tapc_pkg.sv
// Shared TAP controller types: 1149.1 state encoding, DR select indices and next-state rule.
package scr1_tapc_pkg;

  typedef enum logic [3:0] {
    TapTestLogicReset,
    TapRunTestIdle,
    TapSelectDrScan,
    TapCaptureDr,
    TapShiftDr,
    TapExit1Dr,
    TapPauseDr,
    TapExit2Dr,
    TapUpdateDr,
    TapSelectIrScan,
    TapCaptureIr,
    TapShiftIr,
    TapExit1Ir,
    TapPauseIr,
    TapExit2Ir,
    TapUpdateIr
  } tap_state_e;

  localparam int unsigned DrBypass = 0;
  localparam int unsigned DrIdcode = 1;
  localparam int unsigned DrDtmcs  = 2;
  localparam int unsigned DrDmi    = 3;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    unique case (s)
      TapTestLogicReset: tap_next = tms ? TapTestLogicReset : TapRunTestIdle;
      TapRunTestIdle:    tap_next = tms ? TapSelectDrScan   : TapRunTestIdle;
      TapSelectDrScan:   tap_next = tms ? TapSelectIrScan   : TapCaptureDr;
      TapCaptureDr:      tap_next = tms ? TapExit1Dr        : TapShiftDr;
      TapShiftDr:        tap_next = tms ? TapExit1Dr        : TapShiftDr;
      TapExit1Dr:        tap_next = tms ? TapUpdateDr       : TapPauseDr;
      TapPauseDr:        tap_next = tms ? TapExit2Dr        : TapPauseDr;
      TapExit2Dr:        tap_next = tms ? TapUpdateDr       : TapShiftDr;
      TapUpdateDr:       tap_next = tms ? TapSelectDrScan   : TapRunTestIdle;
      TapSelectIrScan:   tap_next = tms ? TapTestLogicReset : TapCaptureIr;
      TapCaptureIr:      tap_next = tms ? TapExit1Ir        : TapShiftIr;
      TapShiftIr:        tap_next = tms ? TapExit1Ir        : TapShiftIr;
      TapExit1Ir:        tap_next = tms ? TapUpdateIr       : TapPauseIr;
      TapPauseIr:        tap_next = tms ? TapExit2Ir        : TapPauseIr;
      TapExit2Ir:        tap_next = tms ? TapUpdateIr       : TapShiftIr;
      TapUpdateIr:       tap_next = tms ? TapSelectDrScan   : TapRunTestIdle;
      default:           tap_next = TapTestLogicReset;
    endcase
  endfunction

endpackage

// File: rtl/scr1_tapc_ir_reg.sv
// Instruction register: capture/shift chain plus the parallel IR updated from it.
module scr1_tapc_ir_reg #(
  parameter int unsigned           Width    = 5,
  parameter logic [Width-1:0]      ResetVal = Width'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tdi,
  input  logic             capture,
  input  logic             shift,
  input  logic             update,
  input  logic             tlr_load,
  output logic             ir_shift_lsb,
  output logic [Width-1:0] ir
);

  localparam logic [Width-1:0] CaptureVal = Width'(2'b01);

  logic [Width-1:0] ir_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_shift <= '0;
      ir       <= ResetVal;
    end else begin
      if (capture) begin
        ir_shift <= CaptureVal;
      end else if (shift) begin
        ir_shift <= {tdi, ir_shift[Width-1:1]};
      end
      // Entering Test-Logic-Reset wins; Update-IR can never lead there directly anyway.
      if (tlr_load) begin
        ir <= ResetVal;
      end else if (update) begin
        ir <= ir_shift;
      end
    end
  end

  assign ir_shift_lsb = ir_shift[0];

endmodule

// File: rtl/scr1_tapc_fsm_ctrl.sv
// TAP controller: 1149.1 state machine, IR, DR select decode and TDO mux.
module scr1_tapc_fsm_ctrl
  import scr1_tapc_pkg::*;
#(
  parameter int unsigned                SCR1_IR_WIDTH  = 5,
  parameter logic [SCR1_IR_WIDTH-1:0]   SCR1_IR_IDCODE = 5'h01,
  parameter logic [SCR1_IR_WIDTH-1:0]   SCR1_IR_DTMCS  = 5'h10,
  parameter logic [SCR1_IR_WIDTH-1:0]   SCR1_IR_DMI    = 5'h11,
  parameter logic [SCR1_IR_WIDTH-1:0]   SCR1_IR_BYPASS = 5'h1F
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tms,
  input  logic                     tdi,
  input  logic [3:0]               dr_tdo,
  output logic [3:0]               fsm_dr_select,
  output logic                     fsm_dr_capture,
  output logic                     fsm_dr_shift,
  output logic                     fsm_dr_update,
  output logic                     tap_rst_n,
  output logic                     tdo,
  output logic                     tdo_en,
  output logic [SCR1_IR_WIDTH-1:0] ir
);

  tap_state_e state;
  tap_state_e state_next;
  logic       ir_shift_lsb;
  logic [1:0] dr_idx;

  always_comb state_next = tap_next(state, tms);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TapTestLogicReset;
    end else begin
      state <= state_next;
    end
  end

  scr1_tapc_ir_reg #(
    .Width    (SCR1_IR_WIDTH),
    .ResetVal (SCR1_IR_IDCODE)
  ) u_ir_reg (
    .clk          (clk),
    .rst          (rst),
    .tdi          (tdi),
    .capture      (state == TapCaptureIr),
    .shift        (state == TapShiftIr),
    .update       (state == TapUpdateIr),
    .tlr_load     (state_next == TapTestLogicReset),
    .ir_shift_lsb (ir_shift_lsb),
    .ir           (ir)
  );

  assign fsm_dr_capture = (state == TapCaptureDr);
  assign fsm_dr_shift   = (state == TapShiftDr);
  assign fsm_dr_update  = (state == TapUpdateDr);
  assign tap_rst_n      = (state != TapTestLogicReset);
  assign tdo_en         = (state == TapShiftDr) || (state == TapShiftIr);

  // Any opcode not explicitly decoded falls back to BYPASS.
  always_comb begin
    if (ir == SCR1_IR_IDCODE) begin
      dr_idx = 2'(DrIdcode);
    end else if (ir == SCR1_IR_DTMCS) begin
      dr_idx = 2'(DrDtmcs);
    end else if (ir == SCR1_IR_DMI) begin
      dr_idx = 2'(DrDmi);
    end else if (ir == SCR1_IR_BYPASS) begin
      dr_idx = 2'(DrBypass);
    end else begin
      dr_idx = 2'(DrBypass);
    end
  end

  always_comb begin
    fsm_dr_select         = '0;
    fsm_dr_select[dr_idx] = 1'b1;
  end

  always_comb begin
    tdo = 1'b0;
    if (state == TapShiftIr) begin
      tdo = ir_shift_lsb;
    end else if (state == TapShiftDr) begin
      tdo = dr_tdo[dr_idx];
    end
  end

endmodule

// File: tb/tb_scr1_tapc_fsm_ctrl.sv
// Self-checking bench: directed TAP scans plus random TMS/TDI against a table-driven model.
module tb_scr1_tapc_fsm_ctrl;

  logic       clk = 1'b0;
  logic       rst, tms, tdi;
  logic [3:0] dr_tdo = 4'h0;
  logic [3:0] fsm_dr_select;
  logic       fsm_dr_capture, fsm_dr_shift, fsm_dr_update;
  logic       tap_rst_n, tdo, tdo_en;
  logic [4:0] ir;

  scr1_tapc_fsm_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .tms            (tms),
    .tdi            (tdi),
    .dr_tdo         (dr_tdo),
    .fsm_dr_select  (fsm_dr_select),
    .fsm_dr_capture (fsm_dr_capture),
    .fsm_dr_shift   (fsm_dr_shift),
    .fsm_dr_update  (fsm_dr_update),
    .tap_rst_n      (tap_rst_n),
    .tdo            (tdo),
    .tdo_en         (tdo_en),
    .ir             (ir)
  );

  always #5 clk = ~clk;

  // Model state numbering, independent of the RTL.
  localparam int TLR = 0, IDLE = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PSDR = 6;
  localparam int EX2DR = 7, UPDDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12;
  localparam int PSIR = 13, EX2IR = 14, UPDIR = 15;

  int nxt0 [16] = '{IDLE, IDLE, CAPDR, SHDR, SHDR, PSDR, PSDR, SHDR,
                    IDLE, CAPIR, SHIR, SHIR, PSIR, PSIR, SHIR, IDLE};
  int nxt1 [16] = '{TLR, SELDR, SELIR, EX1DR, EX1DR, UPDDR, EX2DR, UPDDR,
                    SELDR, TLR, EX1IR, EX1IR, UPDIR, EX2IR, UPDIR, SELDR};

  int         m_state = TLR;
  bit         m_q[$];        // IR shift chain, element 0 is the bit nearest TDO
  logic [4:0] m_ir = 5'h01;
  int         errors = 0;
  int         checks = 0;
  int         cap_seen = 0;
  int         upd_seen = 0;

  function automatic int sel_idx(input logic [4:0] v);
    case (v)
      5'h01:   return 1;
      5'h10:   return 2;
      5'h11:   return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [4:0] pack_q();
    logic [4:0] v;
    for (int i = 0; i < 5; i++) v[i] = m_q[i];
    return v;
  endfunction

  task automatic load_q(input logic [4:0] v);
    m_q.delete();
    for (int i = 0; i < 5; i++) m_q.push_back(v[i]);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic t, input logic d);
    if (r) begin
      m_state = TLR;
      m_ir    = 5'h01;
      load_q(5'h00);
    end else begin
      if (m_state == CAPIR) begin
        load_q(5'h01);
      end else if (m_state == SHIR) begin
        void'(m_q.pop_front());
        m_q.push_back(d);
      end
      if (m_state == UPDIR) m_ir = pack_q();
      m_state = t ? nxt1[m_state] : nxt0[m_state];
      if (m_state == TLR) m_ir = 5'h01;
    end
  endtask

  task automatic cycle(input logic r, input logic t, input logic d);
    logic [14:0] exp_v;
    logic        exp_tdo;
    rst = r;
    tms = t;
    tdi = d;
    @(posedge clk);
    model_edge(r, t, d);
    #1 dr_tdo = 4'($urandom);
    #1;
    exp_tdo = 1'b0;
    if (m_state == SHIR) exp_tdo = m_q[0];
    else if (m_state == SHDR) exp_tdo = dr_tdo[sel_idx(m_ir)];
    exp_v = {m_state != TLR, m_state == CAPDR, m_state == SHDR, m_state == UPDDR,
             (m_state == SHDR) || (m_state == SHIR), exp_tdo, 4'(1 << sel_idx(m_ir)), m_ir};
    chk("cycle", {tap_rst_n, fsm_dr_capture, fsm_dr_shift, fsm_dr_update, tdo_en, tdo,
                  fsm_dr_select, ir}, exp_v);
    cap_seen += int'(fsm_dr_capture);
    upd_seen += int'(fsm_dr_update);
  endtask

  // Idle -> Shift-IR, shift v LSB-first, Update-IR -> Idle; returns bits seen on tdo.
  task automatic ir_scan(input logic [4:0] v, output logic [4:0] seen);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      seen[i] = tdo;
      cycle(0, i == 4, v[i]);
    end
    cycle(0, 1, 0);
    cycle(0, 0, 0);
  endtask

  task automatic dr_scan(input int n, input int idx);
    cap_seen = 0;
    upd_seen = 0;
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    chk("dr_capture", fsm_dr_capture, 1);
    cycle(0, 0, 0);
    for (int i = 0; i < n; i++) begin
      chk("dr_shift", fsm_dr_shift, 1);
      chk("dr_tdo_sel", tdo, dr_tdo[idx]);
      cycle(0, i == n - 1, 1'($urandom));
    end
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    chk("dr_capture_cnt", cap_seen, 1);
    chk("dr_update_cnt", upd_seen, 1);
  endtask

  initial begin
    logic [4:0] seen;
    logic [4:0] ops [5];
    logic [4:0] v;
    ops = '{5'h01, 5'h10, 5'h11, 5'h1F, 5'h00};

    // Reset, then one tms=0 step into Run-Test/Idle
    cycle(1, 1, 0);
    chk("rst_tap_rst_n", tap_rst_n, 0);
    chk("rst_ir", ir, 5'h01);
    chk("rst_select", fsm_dr_select, 4'b0010);
    chk("rst_strobes", {fsm_dr_capture, fsm_dr_shift, fsm_dr_update, tdo, tdo_en}, 0);
    cycle(0, 0, 0);
    chk("idle_tap_rst_n", tap_rst_n, 1);
    chk("idle_ir", ir, 5'h01);
    chk("idle_select", fsm_dr_select, 4'b0010);

    // IR scan of DMI
    ir_scan(5'h11, seen);
    chk("ir_dmi", ir, 5'h11);
    chk("ir_dmi_select", fsm_dr_select, 4'b1000);
    chk("ir_captured", seen, 5'b00001);

    // DR scan through DMI, ir held
    dr_scan(7, 3);
    chk("dr_ir_hold", ir, 5'h11);

    // Unlisted opcode selects BYPASS
    ir_scan(5'h07, seen);
    chk("ill_select", fsm_dr_select, 4'b0001);
    dr_scan(3, 0);

    // Four tms=1 from Shift-DR stay out of TLR, the fifth enters it
    ir_scan(5'h10, seen);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("tlr_in_shdr", fsm_dr_shift, 1);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0);
    chk("tlr_4_rst_n", tap_rst_n, 1);
    chk("tlr_4_ir", ir, 5'h10);
    cycle(0, 1, 0);
    chk("tlr_5_rst_n", tap_rst_n, 0);
    chk("tlr_5_ir", ir, 5'h01);
    cycle(0, 0, 0);

    // rst mid Shift-IR aborts the scan
    ir_scan(5'h11, seen);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    upd_seen = 0;
    cycle(1, 0, 1);
    chk("abort_ir", ir, 5'h01);
    chk("abort_tdo_en", tdo_en, 0);
    chk("abort_rst_n", tap_rst_n, 0);
    cycle(0, 0, 0);
    chk("abort_no_update", upd_seen, 0);

    // Random opcodes with random-length DR scans
    for (int k = 0; k < 12; k++) begin
      v = ops[$urandom_range(0, 4)];
      if (v == 5'h00) v = 5'($urandom);
      ir_scan(v, seen);
      chk("rnd_ir", ir, v);
      chk("rnd_captured", seen, 5'b00001);
      dr_scan($urandom_range(1, 9), sel_idx(v));
    end

    // Free-running random TMS/TDI with occasional reset
    for (int k = 0; k < 600; k++) begin
      cycle(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 2) == 0), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scr1_tapc_fsm_ctrl.md
SCR1_TAPC_FSM_CTRL -- requirements
Module: scr1_tapc_fsm_ctrl

Interface
REQ-001 SHALL have parameter SCR1_IR_WIDTH, default 5, instruction register width in bits.
REQ-002 SHALL have parameter SCR1_IR_IDCODE, default 5'h01, IDCODE opcode and IR reset value.
REQ-003 SHALL have parameter SCR1_IR_DTMCS, default 5'h10, DTM control/status opcode.
REQ-004 SHALL have parameter SCR1_IR_DMI, default 5'h11, debug module interface opcode.
REQ-005 SHALL have parameter SCR1_IR_BYPASS, default 5'h1F, BYPASS opcode.
REQ-006 SHALL have port clk  input  1  TAP clock; single clock, all state on posedge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port tms  input  1  test mode select, sampled on posedge clk.
REQ-009 SHALL have port tdi  input  1  test data in, shifted into IR during Shift-IR.
REQ-010 SHALL have port dr_tdo  input  4  serial outputs of DRs [0]=BYPASS [1]=IDCODE [2]=DTMCS [3]=DMI.
REQ-011 SHALL have port fsm_dr_select  output  4  one-hot DR select, same indexing as dr_tdo.
REQ-012 SHALL have port fsm_dr_capture / fsm_dr_shift / fsm_dr_update  output  1 each  high while TAP state is Capture-DR / Shift-DR / Update-DR.
REQ-013 SHALL have port tap_rst_n  output  1  low while in Test-Logic-Reset; drives DR rst_n_sync.
REQ-014 SHALL have port tdo  output  1  serial data out.
REQ-015 SHALL have port tdo_en  output  1  high only in Shift-DR or Shift-IR.
REQ-016 SHALL have port ir  output  SCR1_IR_WIDTH  current instruction.

Function
REQ-017 SHALL implement the 16-state IEEE 1149.1 TAP FSM; next state from current state and tms, taken on posedge clk.
REQ-018 SHALL reach Test-Logic-Reset after 5 consecutive tms=1 samples from any state.
REQ-019 SHALL drive fsm_dr_capture/shift/update and tdo_en combinationally from the current state register (no extra latency); DRs act on them at the next edge.
REQ-020 SHALL load the IR shift register with {0..0,2'b01} on the posedge leaving Capture-IR.
REQ-021 SHALL shift the IR shift register right with tdi entering MSB on each posedge while in Shift-IR.
REQ-022 SHALL copy the IR shift register to ir on the posedge leaving Update-IR; ir SHALL otherwise hold.
REQ-023 SHALL decode ir into one-hot fsm_dr_select: IDCODE->bit1, DTMCS->bit2, DMI->bit3, BYPASS and every unlisted opcode->bit0.
REQ-024 SHALL drive tdo = ir_shift[0] in Shift-IR, dr_tdo[selected index] in Shift-DR, 0 otherwise.
REQ-025 SHALL, on entering Test-Logic-Reset by tms, set ir to SCR1_IR_IDCODE on the same edge.
REQ-026 SHALL leave ir unchanged through a DR scan; an IR scan aborted via Exit1/Exit2 without Update-IR SHALL leave ir unchanged.

Reset
REQ-027 SHALL, with rst=1 at posedge, set state=Test-Logic-Reset, ir=SCR1_IR_IDCODE, IR shift register=0, irrespective of tms.
REQ-028 SHALL give reset values: tap_rst_n=0, fsm_dr_select=4'b0010, capture/shift/update=0, tdo=0, tdo_en=0.
REQ-029 SHALL let rst mid-scan abort the scan with no Update-IR/Update-DR pulse emitted.

Structure
REQ-030 SHALL place the TAP state enum (16 states) and DR index constants in shared package scr1_tapc_pkg.
REQ-031 SHALL instantiate one sub-module, scr1_tapc_ir_reg (IR shift + IR register), driven by decoded capture/shift/update-IR strobes.
REQ-032 SHALL keep FSM, DR decode and tdo mux in the top module.

Verification
REQ-033 SHALL cover reset: rst=1 one cycle, tms=0 -> Run-Test/Idle next cycle, ir=5'h01, fsm_dr_select=4'b0010, tap_rst_n=1.
REQ-034 SHALL cover IR scan: from Idle tms 1,1,0,0 then shift 5'h11 LSB-first (last bit with tms=1), tms 1,0 -> ir=5'h11, fsm_dr_select=4'b1000; captured bits out on tdo 1,0,0,0,0.
REQ-035 SHALL cover DR scan: ir=DMI, tms 1,0,0 -> fsm_dr_capture one cycle, fsm_dr_shift and tdo=dr_tdo[3] for each Shift-DR cycle, fsm_dr_update exactly one cycle.
REQ-036 SHALL cover illegal opcode: shift in 5'h07 -> fsm_dr_select=4'b0001 and tdo follows dr_tdo[0].
REQ-037 SHALL cover TLR by tms: from Shift-DR with ir=DTMCS, five tms=1 -> Test-Logic-Reset, tap_rst_n=0, ir=5'h01; four tms=1 SHALL NOT reach TLR.
REQ-038 SHALL cover abort: rst=1 asserted in Shift-IR mid-way -> no Update-IR, ir=5'h01, tdo_en=0 next cycle.
